// File: rtl/tx_hs_multilane_fsm.sv
// Multi-lane D-PHY HS transmit sequencer: ZERO -> SYNC -> DATA -> TRAIL per burst,
// with valid/ready payload prefetch, end-of-burst lane masking and underrun flagging.
module tx_hs_multilane_fsm #(
    parameter int         NUM_LANES   = 2,
    parameter int         ZERO_CNT_W  = 8,
    parameter int         TRAIL_CNT_W = 8,
    parameter logic [7:0] SYNC_BYTE   = 8'h1D,
    parameter int         SYNC_BEATS  = 1
) (
    input  logic                     TX_DDR_clk,
    input  logic                     TX_rst,
    input  logic                     Enable,
    input  logic                     TX_REQUEST_HS,
    input  logic [ZERO_CNT_W-1:0]    cfg_t_hs_zero,
    input  logic [TRAIL_CNT_W-1:0]   cfg_t_hs_trail,
    input  logic                     TX_VALID,
    input  logic [8*NUM_LANES-1:0]   TX_BYTE_DATA,
    input  logic                     TX_HS_END_DATA,
    input  logic [NUM_LANES-1:0]     TX_LAST_KEEP,
    output logic [2:0]               TX_HS_STATE,
    output logic [8*NUM_LANES-1:0]   TX_BYTE_DATA_FSM,
    output logic [NUM_LANES-1:0]     TX_BYTE_DATA_VALID,
    output logic                     TX_HS_READY,
    output logic                     TX_HS_ACTIVE,
    output logic                     TX_UNDERRUN
);

    localparam int CNT_W0 = (ZERO_CNT_W > TRAIL_CNT_W) ? ZERO_CNT_W : TRAIL_CNT_W;
    localparam int CNT_W  = (CNT_W0 < 3) ? 3 : CNT_W0;

    typedef enum logic [2:0] {
        ST_STOP  = 3'd0,
        ST_ZERO  = 3'd1,
        ST_SYNC  = 3'd2,
        ST_DATA  = 3'd3,
        ST_TRAIL = 3'd4
    } state_e;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d, cnt_inc;
    logic [ZERO_CNT_W-1:0]    zero_len_q, zero_len_d;
    logic [TRAIL_CNT_W-1:0]   trail_len_q, trail_len_d;
    logic                     end_seen_q, end_seen_d;
    logic                     underrun_q, underrun_d;
    logic [NUM_LANES-1:0]     last_bit_q, last_bit_d;
    logic [8*NUM_LANES-1:0]   data_q, data_d;
    logic [NUM_LANES-1:0]     valid_q, valid_d;
    logic                     active_q, active_d;

    logic zero_done, sync_done, trail_done, ready, accept, end_beat;

    // Trail level is the inverse of the final bit on the wire (bit7, LSB-first).
    function automatic logic [7:0] trail_byte(input logic last_bit);
        return last_bit ? 8'h00 : 8'hFF;
    endfunction

    assign cnt_inc    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    assign zero_done  = (cnt_q == CNT_W'(zero_len_q) - CNT_W'(1));
    assign sync_done  = (cnt_q == CNT_W'(SYNC_BEATS - 1));
    assign trail_done = (cnt_q == CNT_W'(trail_len_q) - CNT_W'(1));
    assign ready      = ((state_q == ST_SYNC) && sync_done) ||
                        ((state_q == ST_DATA) && !end_seen_q);
    assign accept     = TX_VALID && ready;
    assign end_beat   = accept && TX_HS_END_DATA;

    always_ff @(posedge TX_DDR_clk) begin
        if (TX_rst) begin
            state_q     <= ST_STOP;
            cnt_q       <= '0;
            zero_len_q  <= '0;
            trail_len_q <= '0;
            end_seen_q  <= 1'b0;
            underrun_q  <= 1'b0;
            last_bit_q  <= '0;
            data_q      <= '0;
            valid_q     <= '0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            zero_len_q  <= zero_len_d;
            trail_len_q <= trail_len_d;
            end_seen_q  <= end_seen_d;
            underrun_q  <= underrun_d;
            last_bit_q  <= last_bit_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            active_q    <= active_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        zero_len_d  = zero_len_q;
        trail_len_d = trail_len_q;
        end_seen_d  = end_seen_q;
        underrun_d  = underrun_q;
        last_bit_d  = last_bit_q;
        if (!Enable) begin
            state_d    = ST_STOP;
            cnt_d      = '0;
            end_seen_d = 1'b0;
        end else begin
            case (state_q)
                ST_STOP: begin
                    if (TX_REQUEST_HS) begin
                        state_d     = ST_ZERO;
                        cnt_d       = '0;
                        zero_len_d  = (cfg_t_hs_zero == '0) ? ZERO_CNT_W'(1) : cfg_t_hs_zero;
                        trail_len_d = (cfg_t_hs_trail == '0) ? TRAIL_CNT_W'(1) : cfg_t_hs_trail;
                        underrun_d  = 1'b0;
                        end_seen_d  = 1'b0;
                        last_bit_d  = {NUM_LANES{SYNC_BYTE[7]}};
                    end
                end
                ST_ZERO: begin
                    if (zero_done) begin
                        state_d = ST_SYNC;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_SYNC: begin
                    if (sync_done) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_DATA: begin
                    if (end_seen_q) begin
                        state_d    = ST_TRAIL;
                        cnt_d      = '0;
                        end_seen_d = 1'b0;
                    end
                end
                ST_TRAIL: begin
                    if (trail_done) begin
                        state_d = ST_STOP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = ST_STOP;
                    cnt_d   = '0;
                end
            endcase
            // Masked lanes on the END beat keep the bit history of their previous byte.
            if (accept) begin
                if (end_beat) end_seen_d = 1'b1;
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (!end_beat || TX_LAST_KEEP[i]) last_bit_d[i] = TX_BYTE_DATA[8*i+7];
                end
            end else if (ready) begin
                underrun_d = 1'b1;
            end
        end
    end

    always_comb begin
        data_d   = '0;
        valid_d  = '0;
        active_d = (state_d != ST_STOP);
        case (state_d)
            ST_ZERO: valid_d = '1;
            ST_SYNC: begin
                data_d  = {NUM_LANES{SYNC_BYTE}};
                valid_d = '1;
            end
            ST_DATA: begin
                if (accept) begin
                    valid_d = '1;
                    for (int i = 0; i < NUM_LANES; i++) begin
                        data_d[8*i +: 8] = (end_beat && !TX_LAST_KEEP[i]) ?
                                           trail_byte(last_bit_q[i]) : TX_BYTE_DATA[8*i +: 8];
                    end
                end
            end
            ST_TRAIL: begin
                valid_d = '1;
                for (int i = 0; i < NUM_LANES; i++) data_d[8*i +: 8] = trail_byte(last_bit_q[i]);
            end
            default: ;
        endcase
    end

    assign TX_HS_STATE        = state_q;
    assign TX_BYTE_DATA_FSM   = data_q;
    assign TX_BYTE_DATA_VALID = valid_q;
    assign TX_HS_READY        = ready;
    assign TX_HS_ACTIVE       = active_q;
    assign TX_UNDERRUN        = underrun_q;

endmodule

// File: tb/tb_tx_hs_multilane_fsm.sv
// Scoreboard bench for tx_hs_multilane_fsm: stimulus queues expected beats, a negedge
// monitor pops one per active output cycle; idle/STOP states are checked directly.
module tb_tx_hs_multilane_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        req;
    logic [7:0]  cfg_zero;
    logic [7:0]  cfg_trail;
    logic        tx_valid;
    logic [15:0] tx_data;
    logic        tx_end;
    logic [1:0]  tx_keep;
    logic [2:0]  hs_state;
    logic [15:0] data_fsm;
    logic [1:0]  data_valid;
    logic        hs_ready;
    logic        hs_active;
    logic        underrun;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [2:0]  st;
        logic [15:0] data;
        logic [1:0]  valid;
        logic        ready;
        logic        urun;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    tx_hs_multilane_fsm #(
        .NUM_LANES(2), .ZERO_CNT_W(8), .TRAIL_CNT_W(8), .SYNC_BYTE(8'h1D), .SYNC_BEATS(1)
    ) dut (
        .TX_DDR_clk(clk),
        .TX_rst(rst),
        .Enable(en),
        .TX_REQUEST_HS(req),
        .cfg_t_hs_zero(cfg_zero),
        .cfg_t_hs_trail(cfg_trail),
        .TX_VALID(tx_valid),
        .TX_BYTE_DATA(tx_data),
        .TX_HS_END_DATA(tx_end),
        .TX_LAST_KEEP(tx_keep),
        .TX_HS_STATE(hs_state),
        .TX_BYTE_DATA_FSM(data_fsm),
        .TX_BYTE_DATA_VALID(data_valid),
        .TX_HS_READY(hs_ready),
        .TX_HS_ACTIVE(hs_active),
        .TX_UNDERRUN(underrun)
    );

    // Monitor: every active output cycle must match the next queued expectation.
    always @(negedge clk) begin
        exp_t got;
        exp_t e;
        if (hs_active) begin
            got = '{st: hs_state, data: data_fsm, valid: data_valid, ready: hs_ready, urun: underrun};
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL unexpected_beat got st=%0d data=%h v=%b rdy=%b ur=%b, required no active beat",
                         got.st, got.data, got.valid, got.ready, got.urun);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    tests_failed++;
                    $display("[TB] FAIL beat got st=%0d data=%h v=%b rdy=%b ur=%b, required st=%0d data=%h v=%b rdy=%b ur=%b",
                             got.st, got.data, got.valid, got.ready, got.urun,
                             e.st, e.data, e.valid, e.ready, e.urun);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [2:0] st, input logic [15:0] d, input logic [1:0] v,
                            input logic r, input logic u);
        exp_q.push_back('{st: st, data: d, valid: v, ready: r, urun: u});
    endtask

    task automatic check_idle(input string name, input logic exp_urun);
        @(negedge clk);
        tests_run++;
        if (hs_state !== 3'd0 || data_fsm !== 16'h0 || data_valid !== 2'b00 ||
            hs_ready !== 1'b0 || hs_active !== 1'b0 || underrun !== exp_urun) begin
            tests_failed++;
            $display("[TB] FAIL %s got st=%0d data=%h v=%b rdy=%b act=%b ur=%b, required all zero with ur=%b",
                     name, hs_state, data_fsm, data_valid, hs_ready, hs_active, underrun, exp_urun);
        end
    endtask

    task automatic start_burst(input logic [7:0] z, input logic [7:0] t);
        req       = 1'b1;
        cfg_zero  = z;
        cfg_trail = t;
        step();
        req = 1'b0;
    endtask

    task automatic send_beat(input logic [15:0] d, input logic e, input logic [1:0] k);
        tx_valid = 1'b1;
        tx_data  = d;
        tx_end   = e;
        tx_keep  = k;
        step();
        tx_valid = 1'b0;
        tx_end   = 1'b0;
        tx_keep  = 2'b11;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; req = 1'b0; cfg_zero = 8'd0; cfg_trail = 8'd0;
        tx_valid = 1'b0; tx_data = 16'h0; tx_end = 1'b0; tx_keep = 2'b11;
        repeat (3) step();
        check_idle("reset_state", 1'b0);
        rst = 1'b0;
        step();

        // 1: two full beats, zero=3, trail=2
        repeat (3) push_exp(3'd1, 16'h0000, 2'b11, 1'b0, 1'b0);
        push_exp(3'd2, 16'h1D1D, 2'b11, 1'b1, 1'b0);
        push_exp(3'd3, 16'h1234, 2'b11, 1'b1, 1'b0);
        push_exp(3'd3, 16'h56F7, 2'b11, 1'b0, 1'b0);
        repeat (2) push_exp(3'd4, 16'hFF00, 2'b11, 1'b0, 1'b0);
        start_burst(8'd3, 8'd2);
        repeat (3) step();
        send_beat(16'h1234, 1'b0, 2'b11);
        send_beat(16'h56F7, 1'b1, 2'b11);
        repeat (3) step();
        check_idle("t1_stop", 1'b0);

        // 2: END beat with lane1 masked, lane1 previous byte 0x80
        push_exp(3'd1, 16'h0000, 2'b11, 1'b0, 1'b0);
        push_exp(3'd2, 16'h1D1D, 2'b11, 1'b1, 1'b0);
        push_exp(3'd3, 16'h8001, 2'b11, 1'b1, 1'b0);
        push_exp(3'd3, 16'h007F, 2'b11, 1'b0, 1'b0);
        repeat (2) push_exp(3'd4, 16'h00FF, 2'b11, 1'b0, 1'b0);
        start_burst(8'd1, 8'd2);
        step();
        send_beat(16'h8001, 1'b0, 2'b11);
        send_beat(16'hAA7F, 1'b1, 2'b01);
        repeat (3) step();
        check_idle("t2_stop", 1'b0);

        // 3: one-cycle underrun mid-DATA; flag stays set in STOP
        push_exp(3'd1, 16'h0000, 2'b11, 1'b0, 1'b0);
        push_exp(3'd2, 16'h1D1D, 2'b11, 1'b1, 1'b0);
        push_exp(3'd3, 16'h1122, 2'b11, 1'b1, 1'b0);
        push_exp(3'd3, 16'h0000, 2'b00, 1'b1, 1'b1);
        push_exp(3'd3, 16'h33C4, 2'b11, 1'b0, 1'b1);
        push_exp(3'd4, 16'hFF00, 2'b11, 1'b0, 1'b1);
        start_burst(8'd1, 8'd1);
        step();
        send_beat(16'h1122, 1'b0, 2'b11);
        step();
        send_beat(16'h33C4, 1'b1, 2'b11);
        repeat (2) step();
        check_idle("t3_underrun_held", 1'b1);

        // 4a: reset pulse during ZERO; new burst start clears the underrun flag
        push_exp(3'd1, 16'h0000, 2'b11, 1'b0, 1'b0);
        start_burst(8'd5, 8'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("t4_reset_abort", 1'b0);
        repeat (3) step();
        check_idle("t4_reset_no_trail", 1'b0);

        // 4b: Enable dropped during DATA
        push_exp(3'd1, 16'h0000, 2'b11, 1'b0, 1'b0);
        push_exp(3'd2, 16'h1D1D, 2'b11, 1'b1, 1'b0);
        push_exp(3'd3, 16'hABCD, 2'b11, 1'b1, 1'b0);
        start_burst(8'd1, 8'd3);
        step();
        send_beat(16'hABCD, 1'b0, 2'b11);
        en = 1'b0;
        send_beat(16'hEF01, 1'b0, 2'b11);
        check_idle("t4_enable_abort", 1'b0);
        en = 1'b1;
        repeat (3) step();
        check_idle("t4_enable_no_trail", 1'b0);

        // 5: zero/trail of 0 act as 1; END accepted in the prefetch SYNC beat
        push_exp(3'd1, 16'h0000, 2'b11, 1'b0, 1'b0);
        push_exp(3'd2, 16'h1D1D, 2'b11, 1'b1, 1'b0);
        push_exp(3'd3, 16'h0102, 2'b11, 1'b0, 1'b0);
        push_exp(3'd4, 16'hFFFF, 2'b11, 1'b0, 1'b0);
        start_burst(8'd0, 8'd0);
        step();
        send_beat(16'h0102, 1'b1, 2'b11);
        repeat (2) step();
        check_idle("t5_stop", 1'b0);

        // 6: request held high; cfg change mid-burst only affects the second burst
        repeat (2) push_exp(3'd1, 16'h0000, 2'b11, 1'b0, 1'b0);
        push_exp(3'd2, 16'h1D1D, 2'b11, 1'b1, 1'b0);
        push_exp(3'd3, 16'hFF00, 2'b11, 1'b0, 1'b0);
        push_exp(3'd4, 16'h00FF, 2'b11, 1'b0, 1'b0);
        push_exp(3'd1, 16'h0000, 2'b11, 1'b0, 1'b0);
        push_exp(3'd2, 16'h1D1D, 2'b11, 1'b1, 1'b0);
        push_exp(3'd3, 16'hFF90, 2'b11, 1'b0, 1'b0);
        repeat (2) push_exp(3'd4, 16'hFF00, 2'b11, 1'b0, 1'b0);
        req = 1'b1; cfg_zero = 8'd2; cfg_trail = 8'd1;
        step();
        cfg_zero = 8'd1; cfg_trail = 8'd2;
        repeat (2) step();
        send_beat(16'hFF00, 1'b1, 2'b11);
        repeat (2) step();
        check_idle("t6_stop_gap", 1'b0);
        step();
        req = 1'b0;
        step();
        send_beat(16'h1090, 1'b1, 2'b01);
        repeat (3) step();
        check_idle("t6_stop_end", 1'b0);

        repeat (3) step();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL scoreboard_drain got %0d beats pending, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
